// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam logic [15:0] ID_WORD_DEFAULT = 16'h7C05;

  // Write flag position, counted down from the command word MSB
  localparam int CMD_BIT_FROM_MSB = 0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI word-level register controller: command decode, config/status register
// file, auto-incrementing burst access and sticky read-only-write error.
//
// state    | meaning
// ST_IDLE  | awaiting command word, o_win shows ID_WORD
// ST_WRITE | each data word writes the current address, then increments
// ST_READ  | each word advances the address and presents its contents
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 8,
  parameter logic [WORD_SIZE-1:0] ID_WORD = WORD_SIZE'(ID_WORD_DEFAULT),
  localparam int ADDR_BITS = $clog2(NUM_REGS),
  localparam int NUM_CFG   = NUM_REGS / 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sce,
  input  logic                         i_wstb,
  input  logic [WORD_SIZE-1:0]         i_wout,
  output logic [WORD_SIZE-1:0]         o_win,
  input  logic [NUM_CFG*WORD_SIZE-1:0] i_status,
  output logic [NUM_CFG*WORD_SIZE-1:0] o_cfg,
  output logic                         o_wr_stb,
  output logic [ADDR_BITS-1:0]         o_wr_addr,
  output logic                         o_err
);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   win_d;
  logic [WORD_SIZE-1:0]   cfg_q [NUM_CFG];
  logic                   sce_q;
  logic                   frame_idle;
  logic                   wr_en, err_set, err_clr;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [ADDR_BITS-2:0]   rd_idx;
  logic [WORD_SIZE-1:0]   rd_data;

  sync_2ff #(.RST_VAL(1'b1)) u_sce_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (i_sce),
    .q     (sce_q)
  );

  assign frame_idle = sce_q;

  for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_pack
    assign o_cfg[k*WORD_SIZE +: WORD_SIZE] = cfg_q[k];
  end

  // In IDLE the word about to be read is the command's start address;
  // in READ it is the next address in the burst.
  always_comb begin
    rd_addr = (state_q == ST_IDLE) ? i_wout[ADDR_BITS-1:0] : addr_q + ADDR_BITS'(1);
    rd_idx  = rd_addr[ADDR_BITS-2:0];
    if (rd_addr[ADDR_BITS-1])
      rd_data = i_status[rd_idx*WORD_SIZE +: WORD_SIZE];
    else
      rd_data = cfg_q[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    win_d   = o_win;
    wr_en   = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    if (frame_idle) begin
      state_d = ST_IDLE;
      win_d   = ID_WORD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          win_d = ID_WORD;
          if (i_wstb) begin
            addr_d = i_wout[ADDR_BITS-1:0];
            if (i_wout[WORD_SIZE-1-CMD_BIT_FROM_MSB]) begin
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
              win_d   = rd_data;
            end
          end
        end
        ST_WRITE: begin
          if (i_wstb) begin
            addr_d = addr_q + ADDR_BITS'(1);
            if (!addr_q[ADDR_BITS-1])
              wr_en = 1'b1;
            else if (addr_q == ADDR_BITS'(NUM_REGS - 1))
              err_clr = 1'b1;
            else
              err_set = 1'b1;
          end
        end
        ST_READ: begin
          if (i_wstb) begin
            addr_d = addr_q + ADDR_BITS'(1);
            win_d  = rd_data;
          end
        end
        default: begin
          state_d = ST_IDLE;
          win_d   = ID_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      o_win     <= ID_WORD;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
      o_err     <= 1'b0;
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      o_win    <= win_d;
      o_wr_stb <= wr_en;
      if (wr_en) begin
        cfg_q[addr_q[ADDR_BITS-2:0]] <= i_wout;
        o_wr_addr <= addr_q;
      end
      if (err_clr)
        o_err <= 1'b0;
      else if (err_set)
        o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus random frames
// compared against a register-map reference model.
module tb_spi_reg_ctrl;

  localparam logic [15:0] ID = 16'h7C05;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_sce;
  logic        i_wstb;
  logic [15:0] i_wout;
  logic [15:0] o_win;
  logic [63:0] i_status;
  logic [63:0] o_cfg;
  logic        o_wr_stb;
  logic [2:0]  o_wr_addr;
  logic        o_err;

  spi_reg_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_sce     (i_sce),
    .i_wstb    (i_wstb),
    .i_wout    (i_wout),
    .o_win     (o_win),
    .i_status  (i_status),
    .o_cfg     (o_cfg),
    .o_wr_stb  (o_wr_stb),
    .o_wr_addr (o_wr_addr),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: register map and transaction position
  logic [15:0] m_cfg [4];
  logic [15:0] m_status [4];
  int          m_mode;       // 0 awaiting command, 1 writing, 2 reading
  int          m_addr;
  logic        m_err;
  logic [15:0] exp_win;
  logic        exp_stb;
  logic [2:0]  exp_waddr;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [15:0] m_read(input int a);
    return (a < 4) ? m_cfg[a] : m_status[a - 4];
  endfunction

  function automatic logic [63:0] m_cfg_packed();
    return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_cfg[k] = '0;
    m_mode = 0; m_addr = 0; m_err = 1'b0;
    exp_win = ID; exp_stb = 1'b0; exp_waddr = '0;
  endtask

  task automatic model_word(input logic [15:0] w);
    exp_stb = 1'b0;
    if (m_mode == 0) begin
      m_addr = int'(w[2:0]);
      if (w[15]) begin
        m_mode = 1;
        exp_win = ID;
      end else begin
        m_mode = 2;
        exp_win = m_read(m_addr);
      end
    end else if (m_mode == 1) begin
      if (m_addr < 4) begin
        m_cfg[m_addr] = w;
        exp_stb = 1'b1;
        exp_waddr = 3'(m_addr);
      end else if (m_addr == 7) begin
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_addr = (m_addr + 1) % 8;
    end else begin
      m_addr = (m_addr + 1) % 8;
      exp_win = m_read(m_addr);
    end
  endtask

  task automatic check_all(input string tag);
    n_cmp++;
    assert (o_win === exp_win) else begin
      n_fail++; $error("FAIL %s o_win observed=%h expected=%h", tag, o_win, exp_win);
    end
    n_cmp++;
    assert (o_cfg === m_cfg_packed()) else begin
      n_fail++; $error("FAIL %s o_cfg observed=%h expected=%h", tag, o_cfg, m_cfg_packed());
    end
    n_cmp++;
    assert (o_wr_stb === exp_stb) else begin
      n_fail++; $error("FAIL %s o_wr_stb observed=%b expected=%b", tag, o_wr_stb, exp_stb);
    end
    n_cmp++;
    assert (o_wr_addr === exp_waddr) else begin
      n_fail++; $error("FAIL %s o_wr_addr observed=%0d expected=%0d", tag, o_wr_addr, exp_waddr);
    end
    n_cmp++;
    assert (o_err === m_err) else begin
      n_fail++; $error("FAIL %s o_err observed=%b expected=%b", tag, o_err, m_err);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input string tag);
    @(negedge i_clk);
    i_wstb = 1'b1;
    i_wout = w;
    @(negedge i_clk);
    i_wstb = 1'b0;
    model_word(w);
    check_all(tag);
  endtask

  task automatic start_frame();
    @(negedge i_clk);
    i_sce = 1'b0;
    repeat (3) @(negedge i_clk);
    exp_stb = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    @(negedge i_clk);
    i_sce = 1'b1;
    repeat (3) @(negedge i_clk);
    m_mode = 0;
    exp_win = ID;
    exp_stb = 1'b0;
    check_all(tag);
  endtask

  task automatic set_status(input int k, input logic [15:0] v);
    m_status[k] = v;
    i_status = {m_status[3], m_status[2], m_status[1], m_status[0]};
  endtask

  initial begin
    logic [15:0] cmd;
    int          nw;

    i_rst = 1'b1; i_sce = 1'b1; i_wstb = 1'b0; i_wout = '0;
    for (int k = 0; k < 4; k++) set_status(k, 16'h1000 + 16'(k));
    model_reset();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check_all("reset");

    // Idle frame presents the ID word
    start_frame();
    check_all("idle_id");

    send_word(16'h8002, "wr_cmd");
    send_word(16'h1234, "wr_data2");
    @(negedge i_clk);
    exp_stb = 1'b0;
    check_all("wr_stb_drop");
    end_frame("wr_end");

    // Burst read wrapping from config into status space
    start_frame();
    send_word(16'h8003, "beef_cmd");
    send_word(16'hBEEF, "beef_data");
    end_frame("beef_end");
    set_status(0, 16'h0042);
    set_status(1, 16'hA5C3);
    start_frame();
    send_word(16'h0003, "rd_cmd3");
    send_word(16'h0000, "rd_addr4");
    send_word(16'h0000, "rd_addr5");
    end_frame("rd_end_id");

    // Read-only write sets the sticky error, write to the last address clears it
    start_frame();
    send_word(16'h8005, "ro_cmd");
    send_word(16'hFFFF, "ro_data");
    end_frame("ro_end");
    start_frame();
    send_word(16'h8007, "clr_cmd");
    send_word(16'h0F0F, "clr_data");
    end_frame("clr_end");

    // Data strobe landing exactly when the frame goes idle is dropped
    start_frame();
    send_word(16'h8001, "abort_cmd");
    @(negedge i_clk);
    i_sce = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_wstb = 1'b1;
    i_wout = 16'h9999;
    @(negedge i_clk);
    i_wstb = 1'b0;
    m_mode = 0;
    exp_win = ID;
    check_all("abort_drop");
    start_frame();
    send_word(16'h0001, "abort_newcmd");
    end_frame("abort_end");

    // Reset mid-write: the next word is a fresh command
    start_frame();
    send_word(16'h8000, "rst_cmd");
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    check_all("rst_state");
    repeat (3) @(negedge i_clk);
    send_word(16'h5555, "rst_next_cmd");
    end_frame("rst_end");

    // Random frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) set_status($urandom_range(0, 3), 16'($urandom));
      start_frame();
      cmd = 16'($urandom);
      send_word(cmd, "rnd_cmd");
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) send_word(16'($urandom), "rnd_data");
      end_frame("rnd_end");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
